// File: rtl/task_dispatcher_if.sv
// Signal bundle linking the task FIFO, the BMW PIFO command/response path
// and the tagged result output of task_dispatcher.
interface task_dispatcher_if #(
    parameter int PTW           = 16,
    parameter int TREE_NUM      = 4,
    parameter int TREE_NUM_BITS = $clog2(TREE_NUM)
) ();
    logic                     fifo_empty;
    logic                     fifo_rd_en;
    logic [PTW+TREE_NUM_BITS:0] fifo_task;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_push;
    logic [TREE_NUM_BITS-1:0] cmd_tree;
    logic [PTW-1:0]           cmd_data;

    logic                     resp_valid;
    logic [PTW-1:0]           resp_data;

    logic                     out_valid;
    logic [TREE_NUM_BITS-1:0] out_tree;
    logic [PTW-1:0]           out_data;

    modport master (
        input  fifo_empty, fifo_task, cmd_ready, resp_valid, resp_data,
        output fifo_rd_en, cmd_valid, cmd_push, cmd_tree, cmd_data,
               out_valid, out_tree, out_data
    );

    modport slave (
        output fifo_empty, fifo_task, cmd_ready, resp_valid, resp_data,
        input  fifo_rd_en, cmd_valid, cmd_push, cmd_tree, cmd_data,
               out_valid, out_tree, out_data
    );
endinterface

// File: rtl/task_dispatcher.sv
// Pops {op, tree, data} tasks from the task FIFO, drops illegal ones using
// per-tree occupancy, issues push/pop commands and tags pop results.
module task_dispatcher #(
    parameter int PTW           = 16,
    parameter int TREE_NUM      = 4,
    parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
    parameter int TREE_CAP      = 8,
    parameter int CNT_W         = $clog2(TREE_CAP + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    task_dispatcher_if.master   bus,
    output logic [15:0]         drop_cnt,
    output logic                busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_ISSUE,
        S_WAIT_RESP
    } state_t;

    state_t                   r_state;
    state_t                   w_next;

    logic                     r_op;
    logic [TREE_NUM_BITS-1:0] r_tree;
    logic [PTW-1:0]           r_data;
    logic [CNT_W-1:0]         r_occ [TREE_NUM];
    logic [15:0]              r_drop_cnt;
    logic                     r_out_valid;
    logic [TREE_NUM_BITS-1:0] r_out_tree;
    logic [PTW-1:0]           r_out_data;

    logic                     w_tree_ok;
    logic [CNT_W-1:0]         w_occ_cur;
    logic                     w_illegal;
    logic                     w_drop;
    logic                     w_handshake;
    logic                     w_resp_take;

    // Out-of-range ids only exist when TREE_NUM is not a power of two.
    assign w_tree_ok = (int'(r_tree) < TREE_NUM);
    assign w_occ_cur = w_tree_ok ? r_occ[r_tree] : '0;
    assign w_illegal = !w_tree_ok ||
                       (r_op ? (w_occ_cur == CNT_W'(TREE_CAP)) : (w_occ_cur == '0));

    assign w_handshake = (r_state == S_ISSUE) && bus.cmd_ready;
    assign w_resp_take = (r_state == S_WAIT_RESP) && bus.resp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_next         = r_state;
        bus.fifo_rd_en = 1'b0;
        bus.cmd_valid  = 1'b0;
        w_drop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by rst_n so the read strobe drops the moment reset asserts.
                if (!bus.fifo_empty && rst_n) begin
                    bus.fifo_rd_en = 1'b1;
                    w_next         = S_FETCH;
                end
            end
            S_FETCH: w_next = S_CHECK;
            S_CHECK: begin
                if (w_illegal) begin
                    w_drop = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.cmd_valid = 1'b1;
                if (bus.cmd_ready) w_next = r_op ? S_IDLE : S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (bus.resp_valid) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= 1'b0;
            r_tree      <= '0;
            r_data      <= '0;
            r_drop_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_tree  <= '0;
            r_out_data  <= '0;
            // NOTE: the occupancy array is reset explicitly; it is tiny flop state
            // that gates legality, not a RAM whose contents may start undefined.
            for (int i = 0; i < TREE_NUM; i++) r_occ[i] <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == S_FETCH) {r_op, r_tree, r_data} <= bus.fifo_task;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
            if (w_handshake) begin
                if (r_op) r_occ[r_tree] <= r_occ[r_tree] + CNT_W'(1);
                else      r_occ[r_tree] <= r_occ[r_tree] - CNT_W'(1);
            end
            if (w_resp_take) begin
                r_out_valid <= 1'b1;
                r_out_tree  <= r_tree;
                r_out_data  <= bus.resp_data;
            end
        end
    end

    assign bus.cmd_push  = r_op;
    assign bus.cmd_tree  = r_tree;
    assign bus.cmd_data  = r_op ? r_data : '0;
    assign bus.out_valid = r_out_valid;
    assign bus.out_tree  = r_out_tree;
    assign bus.out_data  = r_out_data;
    assign drop_cnt      = r_drop_cnt;
    assign busy          = (r_state != S_IDLE);
endmodule

// File: doc/task_dispatcher.md
Name: task_dispatcher

Overview:
- Consumer end of the task FIFO that feeds the BMW PIFO trees.
- Pops encoded tasks {op, tree_id, data} from the FIFO and decodes them into push/pop commands to the PIFO with a valid/ready handshake.
- Tracks per-tree occupancy and drops illegal tasks: push to a full tree, pop from an empty tree.
- Returns pop results tagged with their tree id.

Parameters:
- PTW, 16, payload data width.
- TREE_NUM, 4, number of logical PIFO trees.
- TREE_NUM_BITS, $clog2(TREE_NUM), tree id width.
- TREE_CAP, 8, maximum elements per tree.
- CNT_W, $clog2(TREE_CAP+1), occupancy counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fifo_empty  in  1  task FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe
- fifo_task  in  PTW+TREE_NUM_BITS+1  FIFO output: [MSB]=op (1 push, 0 pop), next TREE_NUM_BITS=tree id, [PTW-1:0]=data
- cmd_valid  out  1  command to PIFO valid
- cmd_ready  in  1  PIFO accepts command
- cmd_push  out  1  1=push, 0=pop
- cmd_tree  out  TREE_NUM_BITS  target tree
- cmd_data  out  PTW  push data (0 for pop)
- resp_valid  in  1  PIFO pop result valid
- resp_data  in  PTW  PIFO pop result
- out_valid  out  1  tagged pop result valid (1-cycle pulse)
- out_tree  out  TREE_NUM_BITS  tree id of result
- out_data  out  PTW  pop result data
- drop_cnt  out  16  saturating count of dropped tasks
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all outputs 0; all occupancy counters 0; drop_cnt 0; the captured task register is cleared. A task in flight is lost; fifo_rd_en deasserts immediately.
- FIFO read latency: data appears on fifo_task the cycle after fifo_rd_en=1. fifo_task is captured only in that cycle.
- FSM states: IDLE, FETCH, CHECK, ISSUE, WAIT_RESP.
- IDLE:
  - If fifo_empty=0: fifo_rd_en=1 for exactly one cycle, go to FETCH.
  - Otherwise stay. fifo_rd_en is never asserted while fifo_empty=1.
- FETCH: register fifo_task into op/tree/data, go to CHECK.
- CHECK:
  - Push with occ[tree]==TREE_CAP, or pop with occ[tree]==0: drop the task, drop_cnt+=1 (saturate at 16'hFFFF), go to IDLE.
  - Otherwise go to ISSUE.
  - Tree id >= TREE_NUM (non-power-of-2 TREE_NUM): dropped the same way.
- ISSUE:
  - cmd_valid=1, with cmd_* driven from registers and stable until handshake.
  - On cmd_valid && cmd_ready:
    - Push: occ[tree]+=1, go to IDLE.
    - Pop: occ[tree]-=1, go to WAIT_RESP.
  - cmd_valid drops the cycle after the handshake.
- WAIT_RESP:
  - Exactly one pop is outstanding at a time.
  - On resp_valid: out_valid=1 next cycle, out_tree=the pop's tree, out_data=resp_data. Go to IDLE.
  - resp_valid in any other state is ignored.
- out_tree/out_data hold their last value when out_valid=0.
- Throughput: minimum 4 cycles per push task (IDLE→FETCH→CHECK→ISSUE with cmd_ready=1). A dropped task takes 3 cycles.
- Occupancy counters never wrap. Only one counter changes per cycle.
- busy=1 in every state except IDLE.

Test Plan:
- Reset, then FIFO delivers push {1, tree 2, 16'h00AB} with cmd_ready=1 -> fifo_rd_en pulse at cycle 0; cmd_valid=1, cmd_push=1, cmd_tree=2, cmd_data=16'h00AB at cycle 3; occ[2]=1; drop_cnt=0.
- Pop on tree 2 after the above; resp_valid with 16'h00AB three cycles after the handshake -> out_valid pulse of one cycle, out_tree=2, out_data=16'h00AB; occ[2]=0.
- Pop to empty tree 1 -> no cmd_valid, drop_cnt=1, FSM back in IDLE 3 cycles after fifo_rd_en.
- Nine pushes to tree 0 (TREE_CAP=8) -> eight cmd handshakes, ninth dropped, drop_cnt=1, occ[0]=8.
- cmd_ready held 0 for 5 cycles during a push -> cmd_valid/cmd_tree/cmd_data stable for all 5 cycles; no further fifo_rd_en until after the handshake.
- rst_n asserted while in WAIT_RESP, then a late resp_valid -> all outputs 0, occupancy 0, no out_valid; after release, normal dispatch resumes.
